// File: rtl/cla_sweep_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cla_sweep_adder                                               |
// | Brief    : Multi-cycle Brent-Kung carry-lookahead adder: one tree level  |
// |            per clock, up-sweep of group G/P then down-sweep of carries.  |
// |            Optional define CLA_OVF_EN adds a signed-overflow output ovf. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module cla_sweep_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             G,
`ifdef CLA_OVF_EN
    output logic             P,
    output logic             ovf
`else
    output logic             P
`endif
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int c_KW   = (LEVELS > 1) ? $clog2(LEVELS) : 1;
    localparam logic [c_KW-1:0] c_K_TOP  = c_KW'(LEVELS - 1);
    localparam logic [c_KW-1:0] c_K_ZERO = '0;
    localparam logic [c_KW-1:0] c_K_ONE  = c_KW'(1);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LOAD = 3'd1;
    localparam logic [2:0] c_UP   = 3'd2;
    localparam logic [2:0] c_DOWN = 3'd3;
    localparam logic [2:0] c_SUM  = 3'd4;
    localparam logic [2:0] c_DONE = 3'd5;

    logic [2:0]       r_state;
    logic [c_KW-1:0]  r_k;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_ci;
    logic [WIDTH-1:0] r_g;   // tree nodes, overwritten in place by the up-sweep
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_pb;  // untouched bit propagates, needed for the final sum
    logic [WIDTH:0]   r_c;

    logic [LEVELS-1:0][WIDTH-1:0] w_up_g;
    logic [LEVELS-1:0][WIDTH-1:0] w_up_p;
    logic [LEVELS-1:0][WIDTH:0]   w_dn_c;

    // Level lv: node j (top of a 2^(lv+1) block) absorbs the node 2^lv below it;
    // on the way down the block midpoint gets its carry from the block base.
    for (genvar lv = 0; lv < LEVELS; lv++) begin : g_lvl
        for (genvar j = 0; j < WIDTH; j++) begin : g_up
            if (((j + 1) % (2 ** (lv + 1))) == 0) begin : g_comb
                assign w_up_g[lv][j] = r_g[j] | (r_p[j] & r_g[j - 2 ** lv]);
                assign w_up_p[lv][j] = r_p[j] & r_p[j - 2 ** lv];
            end else begin : g_pass
                assign w_up_g[lv][j] = r_g[j];
                assign w_up_p[lv][j] = r_p[j];
            end
        end
        for (genvar j = 0; j <= WIDTH; j++) begin : g_dn
            if ((j % (2 ** (lv + 1))) == 2 ** lv) begin : g_mid
                assign w_dn_c[lv][j] = r_g[j - 1] | (r_p[j - 1] & r_c[j - 2 ** lv]);
            end else begin : g_hold
                assign w_dn_c[lv][j] = r_c[j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_k     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_ci    <= 1'b0;
            r_g     <= '0;
            r_p     <= '0;
            r_pb    <= '0;
            r_c     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            co      <= 1'b0;
            G       <= 1'b0;
            P       <= 1'b0;
`ifdef CLA_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_ci    <= ci;
                        busy    <= 1'b1;
                        r_state <= c_LOAD;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_LOAD: begin
                    r_g     <= r_a & r_b;
                    r_p     <= r_a ^ r_b;
                    r_pb    <= r_a ^ r_b;
                    r_c     <= {{WIDTH{1'b0}}, r_ci};
                    r_k     <= c_K_ZERO;
                    r_state <= c_UP;
                end
                c_UP: begin
                    r_g <= w_up_g[r_k];
                    r_p <= w_up_p[r_k];
                    if (r_k == c_K_TOP) begin
                        r_state <= c_DOWN;
                    end else begin
                        r_k <= r_k + c_K_ONE;
                    end
                end
                c_DOWN: begin
                    r_c <= w_dn_c[r_k];
                    if (r_k == c_K_TOP) begin
                        r_c[WIDTH] <= r_g[WIDTH-1] | (r_p[WIDTH-1] & r_c[0]);
                    end
                    if (r_k == c_K_ZERO) begin
                        r_state <= c_SUM;
                    end else begin
                        r_k <= r_k - c_K_ONE;
                    end
                end
                c_SUM: begin
                    sum     <= r_pb ^ r_c[WIDTH-1:0];
                    co      <= r_c[WIDTH];
                    G       <= r_g[WIDTH-1];
                    P       <= r_p[WIDTH-1];
`ifdef CLA_OVF_EN
                    ovf     <= r_c[WIDTH] ^ r_c[WIDTH-1];
`endif
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= c_DONE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cla_sweep_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cla_sweep_adder                                            |
// | Brief    : Directed scoreboard bench for cla_sweep_adder (WIDTH=8).      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_cla_sweep_adder;

    localparam int W   = 8;
    localparam int L   = 3;
    localparam int LAT = 2 * L + 3;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         g;
        logic         p;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         r_rst;
    logic         r_start;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic         r_ci;
    logic         w_busy;
    logic         w_done;
    logic [W-1:0] w_sum;
    logic         w_co;
    logic         w_g;
    logic         w_p;
`ifdef CLA_OVF_EN
    logic         w_ovf;
`endif

    exp_t q_exp[$];
    int   checks = 0;
    int   errors = 0;

    cla_sweep_adder #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst   (r_rst),
        .start (r_start),
        .a     (r_a),
        .b     (r_b),
        .ci    (r_ci),
        .busy  (w_busy),
        .done  (w_done),
        .sum   (w_sum),
        .co    (w_co),
        .G     (w_g),
`ifdef CLA_OVF_EN
        .P     (w_p),
        .ovf   (w_ovf)
`else
        .P     (w_p)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        exp_t         e;
        logic [W:0]   t;
        logic [W:0]   t0;
        t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        t0     = {1'b0, a} + {1'b0, b};
        e.sum  = t[W-1:0];
        e.co   = t[W];
        e.g    = t0[W];
        e.p    = &(a ^ b);
        e.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Presents a request at the falling edge; returns just after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        @(negedge clk);
        r_a     = a;
        r_b     = b;
        r_ci    = ci;
        r_start = 1'b1;
        q_exp.push_back(model(a, b, ci));
        @(posedge clk);
        #1;
        r_start = 1'b0;
        chk("busy_after_accept", 64'(w_busy), 64'(1'b1));
    endtask

    // Counts edges from the accepting edge (=1) until done, then scores the result.
    task automatic wait_done(input string tag, input int cyc0);
        int   cyc;
        exp_t e;
        cyc = cyc0;
        while (!w_done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(LAT));
        chk({tag, "_busy_at_done"}, 64'(w_busy), 64'(1'b0));
        if (q_exp.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 64'(0), 64'(1));
        end else begin
            e = q_exp.pop_front();
            chk({tag, "_sum"}, 64'(w_sum), 64'(e.sum));
            chk({tag, "_co"},  64'(w_co),  64'(e.co));
            chk({tag, "_G"},   64'(w_g),   64'(e.g));
            chk({tag, "_P"},   64'(w_p),   64'(e.p));
`ifdef CLA_OVF_EN
            chk({tag, "_ovf"}, 64'(w_ovf), 64'(e.ovf));
`endif
        end
    endtask

    initial begin
        int   seen;
        exp_t held;
        r_rst   = 1'b1;
        r_start = 1'b0;
        r_a     = '0;
        r_b     = '0;
        r_ci    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(w_busy), 64'(0));
        chk("rst_done", 64'(w_done), 64'(0));
        chk("rst_sum",  64'(w_sum),  64'(0));
        chk("rst_co",   64'(w_co),   64'(0));
        chk("rst_G",    64'(w_g),    64'(0));
        chk("rst_P",    64'(w_p),    64'(0));
        @(negedge clk);
        r_rst = 1'b0;

        issue(8'h12, 8'h34, 1'b0);
        wait_done("add_12_34", 1);
        held = model(8'h12, 8'h34, 1'b0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 64'(w_done), 64'(0));
        chk("sum_held_idle", 64'(w_sum), 64'(held.sum));

        issue(8'hFF, 8'h01, 1'b0);
        wait_done("add_ff_01", 1);
        issue(8'h0F, 8'hF0, 1'b1);
        wait_done("chain_ci1", 1);
        issue(8'h0F, 8'hF0, 1'b0);
        wait_done("chain_ci0", 1);

        // Second request and operand changes while busy must not disturb the op.
        issue(8'h12, 8'h34, 1'b0);
        @(negedge clk);
        r_a     = 8'hFF;
        r_b     = 8'hFF;
        r_ci    = 1'b1;
        r_start = 1'b1;
        @(posedge clk);
        #1;
        r_start = 1'b0;
        wait_done("ignored_start", 2);

        // Request presented in the DONE cycle is accepted immediately.
        issue(8'hA5, 8'h5A, 1'b1);
        wait_done("b2b_first", 1);
        issue(8'h3C, 8'h99, 1'b0);
        wait_done("b2b_second", 1);

        // Abort mid-operation.
        issue(8'h55, 8'h66, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        r_rst = 1'b1;
        #1;
        chk("abort_busy", 64'(w_busy), 64'(0));
        chk("abort_done", 64'(w_done), 64'(0));
        chk("abort_sum",  64'(w_sum),  64'(0));
        chk("abort_co",   64'(w_co),   64'(0));
        chk("abort_G",    64'(w_g),    64'(0));
        chk("abort_P",    64'(w_p),    64'(0));
        void'(q_exp.pop_back());
        @(negedge clk);
        r_rst = 1'b0;
        seen  = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (w_done) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'(0));
        issue(8'h80, 8'h80, 1'b0);
        wait_done("after_abort", 1);

        issue(8'h7F, 8'h01, 1'b0);
        wait_done("ovf_pos", 1);
        issue(8'hFF, 8'h01, 1'b0);
        wait_done("ovf_wrap", 1);

        for (int i = 0; i < 4; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom));
            wait_done("random", 1);
        end

        chk("scoreboard_drained", 64'(q_exp.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
